// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states and cause bit layout.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam int unsigned CAUSE_W   = 4;
  localparam int unsigned CAUSE_POR = 0;
  localparam int unsigned CAUSE_SW  = 1;
  localparam int unsigned CAUSE_WDT = 2;
  localparam int unsigned CAUSE_EXT = 3;

  typedef logic [CAUSE_W-1:0] cause_t;

  localparam cause_t CAUSE_RST_VAL = cause_t'(1 << CAUSE_POR);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Multi-flop synchronizer with asynchronous reset to a configurable value.
module rst_seq_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset generator/sequencer: merges POR, SW, WDT and EXT requests, holds all domains, then releases them in order.
// Optional macro RST_SEQ_DOM_ACK_EN gates each release on the previous domain's synchronized acknowledge.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_DOM       = 3,
  parameter int unsigned ASSERT_CYC  = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_rst_req,
  input  logic             wdt_bite,
  input  logic             ext_rst_req_n,
  input  logic             cause_clr,
`ifdef RST_SEQ_DOM_ACK_EN
  input  logic [N_DOM-1:0] dom_ack,
`endif
  output logic [N_DOM-1:0] rst_out_n,
  output logic             rst_busy,
  output logic             rst_done,
  output logic [3:0]       rst_cause
);

  localparam int unsigned CNT_W = $clog2(max_u(ASSERT_CYC, STAGE_GAP) + 1);
  localparam int unsigned IDX_W = $clog2(N_DOM + 1);

  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
`ifdef RST_SEQ_DOM_ACK_EN
  localparam logic [IDX_W-1:0] IDX_ALL     = IDX_W'(N_DOM);
`else
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_DOM - 1);
`endif

  logic rst_int_s;
  logic ext_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_DOM-1:0]  out_q, out_d, rel_mask;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  cause_t            cause_q, cause_d, req_vec;
  logic              req_any;

  // Async-assert / sync-release of the internal reset
  rst_seq_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_int_s)
  );

  rst_seq_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ext_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ext_rst_req_n),
    .q     (ext_s)
  );

`ifdef RST_SEQ_DOM_ACK_EN
  logic [N_DOM-1:0] ack_s;
  logic             ack_prev;

  for (genvar gi = 0; gi < N_DOM; gi++) begin : g_ack_sync
    rst_seq_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (dom_ack[gi]),
      .q     (ack_s[gi])
    );
  end

  // Acknowledge of the domain released just before the one idx_q points at
  always_comb begin
    ack_prev = 1'b0;
    for (int unsigned i = 0; i < N_DOM; i++) begin
      if (IDX_W'(i + 1) == idx_q) ack_prev = ack_s[i];
    end
  end
`endif

  always_comb begin
    rel_mask = '0;
    for (int unsigned i = 0; i < N_DOM; i++) begin
      if (IDX_W'(i) == idx_q) rel_mask[i] = 1'b1;
    end
  end

  always_comb begin
    req_vec            = '0;
    req_vec[CAUSE_SW]  = sw_rst_req;
    req_vec[CAUSE_WDT] = wdt_bite;
    req_vec[CAUSE_EXT] = ~ext_s;
    req_any            = |req_vec;
    cnt_inc            = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    done_d  = 1'b0;
    cause_d = cause_q;

    if (!rst_int_s) begin
      state_d = ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      out_d   = '0;
      cause_d = CAUSE_RST_VAL;
    end else begin
      // A new request bit survives a simultaneous clear
      cause_d = (cause_clr ? cause_t'(0) : cause_q) | req_vec;

      if (req_any) begin
        state_d = ASSERT;
        cnt_d   = '0;
        idx_d   = '0;
        out_d   = '0;
      end else begin
        unique case (state_q)
          ASSERT: begin
            if (cnt_q >= ASSERT_LAST) begin
              out_d[0] = 1'b1;
              cnt_d    = '0;
`ifdef RST_SEQ_DOM_ACK_EN
              state_d  = RELEASE;
              idx_d    = IDX_W'(1);
`else
              if (N_DOM == 1) begin
                state_d = RUN;
                done_d  = 1'b1;
                idx_d   = '0;
              end else begin
                state_d = RELEASE;
                idx_d   = IDX_W'(1);
              end
`endif
            end else begin
              cnt_d = cnt_inc;
            end
          end
          RELEASE: begin
`ifdef RST_SEQ_DOM_ACK_EN
            if (idx_q == IDX_ALL) begin
              if (ack_s[N_DOM-1]) begin
                state_d = RUN;
                done_d  = 1'b1;
                idx_d   = '0;
              end
            end else if ((cnt_q >= GAP_LAST) && ack_prev) begin
              out_d = out_q | rel_mask;
              cnt_d = '0;
              idx_d = idx_q + IDX_W'(1);
            end else begin
              cnt_d = cnt_inc;
            end
`else
            if (cnt_q >= GAP_LAST) begin
              out_d = out_q | rel_mask;
              cnt_d = '0;
              if (idx_q == IDX_LAST) begin
                state_d = RUN;
                done_d  = 1'b1;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end else begin
              cnt_d = cnt_inc;
            end
`endif
          end
          RUN: begin
            cnt_d = '0;
          end
          default: begin
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            out_d   = '0;
          end
        endcase
      end
    end

    busy_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= CAUSE_RST_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign rst_out_n = out_q;
  assign rst_busy  = busy_q;
  assign rst_done  = done_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: directed scenarios then random requests against a timing model.
module tb_rst_seq_ctrl;

  localparam int unsigned N_DOM       = 3;
  localparam int unsigned ASSERT_CYC  = 16;
  localparam int unsigned STAGE_GAP   = 4;
  localparam int unsigned SYNC_STAGES = 2;

  logic             clk;
  logic             rst_n;
  logic             sw_rst_req;
  logic             wdt_bite;
  logic             ext_rst_req_n;
  logic             cause_clr;
  logic [N_DOM-1:0] rst_out_n;
  logic             rst_busy;
  logic             rst_done;
  logic [3:0]       rst_cause;

  int         n_assert;
  int         n_fail;
  // Edge 1 is the first rising edge that samples rst_n high
  int         ecnt;
  // Edge at which the hold counter was last forced to zero
  int         start;
  logic [3:0] m_cause;
  logic       ext_hist[$];
  int         ext_left;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .N_DOM       (N_DOM),
    .ASSERT_CYC  (ASSERT_CYC),
    .STAGE_GAP   (STAGE_GAP),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw_rst_req    (sw_rst_req),
    .wdt_bite      (wdt_bite),
    .ext_rst_req_n (ext_rst_req_n),
    .cause_clr     (cause_clr),
`ifdef RST_SEQ_DOM_ACK_EN
    .dom_ack       ({N_DOM{1'b1}}),
`endif
    .rst_out_n     (rst_out_n),
    .rst_busy      (rst_busy),
    .rst_done      (rst_done),
    .rst_cause     (rst_cause)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  task automatic model_reset();
    ecnt    = 0;
    start   = 0;
    m_cause = 4'b0001;
    ext_hist.delete();
  endtask

  // One clock: update the model from sampled inputs, then compare on the falling edge
  task automatic tick();
    logic             ext_old;
    logic [3:0]       reqs;
    int               rel0;
    int               last;
    logic [N_DOM-1:0] exp_out;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      ecnt++;
      ext_old = 1'b1;
      if (ext_hist.size() >= SYNC_STAGES) ext_old = ext_hist.pop_front();
      ext_hist.push_back(ext_rst_req_n);
      if (ecnt <= int'(SYNC_STAGES)) begin
        start   = ecnt;
        m_cause = 4'b0001;
      end else begin
        reqs = {~ext_old, wdt_bite, sw_rst_req, 1'b0};
        if (cause_clr) m_cause = 4'b0000;
        m_cause = m_cause | reqs;
        if (reqs != 4'b0000) start = ecnt;
      end
    end
    @(negedge clk);
    rel0 = start + int'(ASSERT_CYC);
    last = rel0 + int'(N_DOM - 1) * int'(STAGE_GAP);
    for (int i = 0; i < int'(N_DOM); i++) exp_out[i] = (ecnt >= rel0 + i * int'(STAGE_GAP));
    chk("rst_out_n", 32'(rst_out_n), 32'(exp_out));
    chk("rst_busy",  32'(rst_busy),  32'(ecnt < last));
    chk("rst_done",  32'(rst_done),  32'(ecnt == last));
    chk("rst_cause", 32'(rst_cause), 32'(m_cause));
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (ecnt < target && guard < 5000) begin
      tick();
      guard++;
    end
    chk("run_to_edge", 32'(ecnt), 32'(target));
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    ext_left      = 0;
    model_reset();
    rst_n         = 1'b1;
    sw_rst_req    = 1'b0;
    wdt_bite      = 1'b0;
    ext_rst_req_n = 1'b1;
    cause_clr     = 1'b0;

    // Power-on reset state
    #2 rst_n = 1'b0;
    #1;
    chk("por_out",   32'(rst_out_n), 32'(0));
    chk("por_busy",  32'(rst_busy),  32'(1));
    chk("por_done",  32'(rst_done),  32'(0));
    chk("por_cause", 32'(rst_cause), 32'(4'b0001));
    repeat (3) tick();
    rst_n = 1'b1;

    run_to(17);
    chk("por_dom0_low",  32'(rst_out_n), 32'(3'b000));
    run_to(18);
    chk("por_dom0_rise", 32'(rst_out_n), 32'(3'b001));
    run_to(22);
    chk("por_dom1_rise", 32'(rst_out_n), 32'(3'b011));
    run_to(26);
    chk("por_done",      32'(rst_done),  32'(1));
    chk("por_all_out",   32'(rst_out_n), 32'(3'b111));
    chk("por_cause_end", 32'(rst_cause), 32'(4'b0001));

    // Software reset from RUN
    run_to(99);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk("sw_out_low", 32'(rst_out_n), 32'(3'b000));
    chk("sw_cause",   32'(rst_cause), 32'(4'b0011));
    run_to(116);
    chk("sw_dom0",    32'(rst_out_n), 32'(3'b001));

    // Watchdog bite aborts the release in progress
    run_to(119);
    wdt_bite = 1'b1;
    tick();
    wdt_bite = 1'b0;
    chk("wdt_abort",  32'(rst_out_n), 32'(3'b000));
    chk("wdt_nodone", 32'(rst_done),  32'(0));
    chk("wdt_cause",  32'(rst_cause), 32'(4'b0111));
    run_to(144);
    chk("wdt_redone", 32'(rst_done),  32'(1));

    // External request held low for 50 cycles
    run_to(199);
    ext_rst_req_n = 1'b0;
    repeat (50) tick();
    ext_rst_req_n = 1'b1;
    chk("ext_held_low", 32'(rst_out_n), 32'(3'b000));
    run_to(266);
    chk("ext_pre_rel",  32'(rst_out_n), 32'(3'b000));
    run_to(267);
    chk("ext_dom0",     32'(rst_out_n), 32'(3'b001));
    chk("ext_cause",    32'(rst_cause), 32'(4'b1111));

    // rst_n asserted mid-release acts immediately
    run_to(299);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    run_to(320);
    chk("mid_rel_out", 32'(rst_out_n), 32'(3'b011));
    rst_n = 1'b0;
    #1;
    chk("async_out",   32'(rst_out_n), 32'(3'b000));
    chk("async_cause", 32'(rst_cause), 32'(4'b0001));
    chk("async_busy",  32'(rst_busy),  32'(1));
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    run_to(18);
    chk("rpor_dom0", 32'(rst_out_n), 32'(3'b001));
    run_to(26);
    chk("rpor_done", 32'(rst_done),  32'(1));

    // Clear and set in the same cycle
    run_to(39);
    wdt_bite = 1'b1;
    tick();
    wdt_bite = 1'b0;
    chk("cause_0101", 32'(rst_cause), 32'(4'b0101));
    run_to(79);
    cause_clr  = 1'b1;
    sw_rst_req = 1'b1;
    tick();
    cause_clr  = 1'b0;
    sw_rst_req = 1'b0;
    chk("clr_set_wins", 32'(rst_cause), 32'(4'b0010));

    // Random requests, clears and external episodes
    for (int c = 0; c < 1200; c++) begin
      sw_rst_req = ($urandom_range(0, 79) == 0);
      wdt_bite   = ($urandom_range(0, 79) == 0);
      cause_clr  = ($urandom_range(0, 29) == 0);
      if (ext_left > 0) begin
        ext_rst_req_n = 1'b0;
        ext_left--;
      end else begin
        ext_rst_req_n = 1'b1;
        if ($urandom_range(0, 149) == 0) ext_left = int'($urandom_range(1, 20));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset generator and sequencer that drives the per-domain reset lines consumed by downstream reset synchronizers. It merges power-on, software, watchdog and external reset requests. It holds all domains in reset for a minimum time, then releases them one by one in ascending index order. It reports busy/done status and a sticky reset cause to the system controller.

Parameters:
N_DOM, 3, number of reset domains driven (1..8)
ASSERT_CYC, 16, minimum cycles all domains are held in reset (>=1)
STAGE_GAP, 4, cycles between successive domain releases (>=1)
SYNC_STAGES, 2, flop depth of the rst_n release synchronizer and the ext_rst_req_n synchronizer (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset; clock clk
sw_rst_req  in  1  synchronous one-cycle software reset request
wdt_bite  in  1  synchronous one-cycle watchdog reset request
ext_rst_req_n  in  1  asynchronous active-low external reset request, level-sensitive
cause_clr  in  1  synchronous pulse; clears rst_cause
rst_out_n  out  N_DOM  per-domain active-low reset, registered
rst_busy  out  1  high while any domain is in reset
rst_done  out  1  one-cycle pulse when the last domain is released
rst_cause  out  4  sticky cause: bit0 POR, bit1 SW, bit2 WDT, bit3 EXT

Behaviour:
- Internal reset: rst_n assertion takes effect asynchronously. Its release passes through a SYNC_STAGES flop chain, giving async-assert / sync-release behaviour.
- While rst_n is low: rst_out_n=0, rst_busy=1, rst_done=0, rst_cause=4'b0001, FSM=ASSERT, counter=0.
- FSM states: ASSERT, RELEASE, RUN.
- ASSERT:
  - Counter increments each cycle.
  - At count ASSERT_CYC, rst_out_n[0] goes high and the FSM moves to RELEASE.
  - Timing from first edge with rst_n high: internal release at edge SYNC_STAGES; rst_out_n[0] rises at edge SYNC_STAGES+ASSERT_CYC.
- RELEASE:
  - rst_out_n[i] rises STAGE_GAP cycles after rst_out_n[i-1].
  - When rst_out_n[N_DOM-1] rises: rst_done=1 for that cycle, rst_busy falls in the same cycle, and the FSM moves to RUN.
  - N_DOM=1: RELEASE is skipped; done and busy change on the same edge as rst_out_n[0].
- RUN:
  - A sw_rst_req or wdt_bite sampled at edge k drives all rst_out_n low and rst_busy high at edge k, and the FSM moves to ASSERT with counter 0.
  - rst_out_n[i] then rises at edge k+ASSERT_CYC+i*STAGE_GAP.
- Synchronized ext_rst_req_n low in any state: the FSM goes to ASSERT, all rst_out_n go low, and the counter is held at 0 while the request stays low. Counting starts on the edge after the synchronized request goes high.
- Request during ASSERT: counter restarts at 0, extending the assertion period.
- Request during RELEASE: abort. All domains re-assert immediately, the FSM returns to ASSERT, and no rst_done is generated.
- Cause register:
  - The bit for each accepted request is set in the cycle the request is accepted. Multiple simultaneous requests set multiple bits.
  - Bits are sticky until cause_clr.
  - cause_clr together with a new request in the same cycle: the new bit is set, all other bits are cleared (set wins).
- Counter width: $clog2(max(ASSERT_CYC,STAGE_GAP)+1). The counter saturates and never wraps.
- rst_out_n is driven only by flops; there is no combinational path from any input to rst_out_n.

Optional Feature:
RST_SEQ_DOM_ACK_EN
- Defined:
  - Adds input dom_ack [N_DOM-1:0], asynchronous, each bit synchronized through SYNC_STAGES flops.
  - Domain i+1 is released only when STAGE_GAP has elapsed and synchronized dom_ack[i]=1, whichever occurs later.
  - The final rst_done additionally waits for synchronized dom_ack[N_DOM-1].
  - There is no timeout; the FSM waits indefinitely.
- Undefined: the port is absent and release is purely timed.

Decomposition:
- Shared package rst_seq_pkg holds:
  - the state enum (ASSERT, RELEASE, RUN)
  - cause bit index constants (CAUSE_POR=0, CAUSE_SW=1, CAUSE_WDT=2, CAUSE_EXT=3)
- One sub-module, rst_seq_sync: a parameterised SYNC_STAGES flop synchronizer. It is instantiated for the rst_n release, for ext_rst_req_n, and for each dom_ack bit.

Test Plan:
- Power-on, defaults: rst_n released before edge 0 -> rst_out_n[0] rises at edge 18, [1] at 22, [2] at 26; rst_done pulses at edge 26 only; rst_cause=4'b0001.
- In RUN, sw_rst_req pulse at edge 100 -> rst_out_n=3'b000 at edge 100; [0] rises at 116, [1] at 120, [2] at 124; rst_cause=4'b0011.
- wdt_bite at edge 120, i.e. mid-RELEASE after the software reset above -> rst_out_n back to 000, no rst_done; re-release at 136/140/144; cause bit2 set.
- ext_rst_req_n held low for 50 cycles in RUN -> all domains stay low throughout; domain 0 releases 2+16 cycles after the request is deasserted; bit3 set.
- cause_clr and sw_rst_req in the same cycle with cause=4'b0101 -> cause=4'b0010.
- rst_n asserted mid-RELEASE -> rst_out_n=000 and cause=4'b0001 immediately (asynchronously); full power-on sequence repeats after release.
